// File: rtl/uart_arb_pkg.sv
// Shared types and defaults for the UART transmit arbiter.
// Holds the arbiter FSM state encoding, the default parameter values
// and the index-width helper used for ACTIVE_ID and the picker.
package uart_arb_pkg;

    localparam int DEF_DATA_WIDTH  = 8;
    localparam int DEF_NUM_REQ     = 4;
    localparam int DEF_TIMEOUT_CYC = 16;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LAUNCH    = 2'd1,
        ST_WAIT_BUSY = 2'd2,
        ST_WAIT_DONE = 2'd3
    } arb_state_e;

    // Width of a requester index; a single requester still gets one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_rr_picker.sv
// Purpose: round-robin winner selection among NUM_REQ requesters.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when the winner is consumed.
//
// Ports:
//   req    - request vector, one bit per requester
//   last   - index of the previous winner; the search starts one above it
//   winner - first requester set at or after last+1, wrapping
//   any    - high when at least one req bit is set
module uart_rr_picker
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ
) (
    input  logic [NUM_REQ-1:0]             req,
    input  logic [idx_width(NUM_REQ)-1:0]  last,
    output logic [idx_width(NUM_REQ)-1:0]  winner,
    output logic                           any
);

    localparam int ID_W = idx_width(NUM_REQ);

    // Walk NUM_REQ positions starting just above the last winner; the
    // previous winner itself is visited last so it has lowest priority.
    always_comb begin
        winner = '0;
        any    = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!any && req[(int'(last) + k) % NUM_REQ]) begin
                any    = 1'b1;
                winner = ID_W'((int'(last) + k) % NUM_REQ);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Purpose: shares one UART transmitter among NUM_REQ byte requesters, round-robin.
// Latency: request to TX_D_VLD/GNT is 1 cycle from IDLE; grants are at least 4 cycles apart.
// Backpressure: requesters hold REQ/data until GNT; no grant while TX_BUSY is high or a byte is in flight.
//
// Ports:
//   CLK, RST   - clock and asynchronous active-low reset
//   REQ        - per-requester send request
//   REQ_DATA   - requester i's byte in [i*DATA_WIDTH +: DATA_WIDTH]
//   GNT        - one-hot, one-cycle byte-accepted pulse
//   TX_P_DATA  - byte to the transmitter, held until the next grant
//   TX_D_VLD   - one-cycle data-valid pulse to the transmitter
//   TX_BUSY    - transmitter busy flag
//   ACTIVE_ID  - index of the current or last granted requester
//   ERR        - one-cycle pulse when TX_BUSY never rose after a launch
//
// Build option: define UART_ARB_TIMEOUT_EN to enable the launch timeout.
// Without it WAIT_BUSY waits forever, ERR is tied low and no counter exists.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int NUM_REQ     = DEF_NUM_REQ,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic                            CLK,
    input  logic                            RST,
    input  logic [NUM_REQ-1:0]              REQ,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   REQ_DATA,
    output logic [NUM_REQ-1:0]              GNT,
    output logic [DATA_WIDTH-1:0]           TX_P_DATA,
    output logic                            TX_D_VLD,
    input  logic                            TX_BUSY,
    output logic [idx_width(NUM_REQ)-1:0]   ACTIVE_ID,
    output logic                            ERR
);

    localparam int ID_W = idx_width(NUM_REQ);

    arb_state_e              state_q, state_d;
    logic [NUM_REQ-1:0]      gnt_q, gnt_d;
    logic                    tx_d_vld_q, tx_d_vld_d;
    logic [DATA_WIDTH-1:0]   tx_p_data_q, tx_p_data_d;
    logic [ID_W-1:0]         active_id_q, active_id_d;
    logic [ID_W-1:0]         last_q, last_d;

    logic [ID_W-1:0]         pick_winner;
    logic                    pick_any;

`ifdef UART_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    err_q, err_d;
`endif

    uart_rr_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_picker (
        .req    (REQ),
        .last   (last_q),
        .winner (pick_winner),
        .any    (pick_any)
    );

    always_comb begin
        state_d     = state_q;
        gnt_d       = '0;
        tx_d_vld_d  = 1'b0;
        tx_p_data_d = tx_p_data_q;
        active_id_d = active_id_q;
        last_d      = last_q;
`ifdef UART_ARB_TIMEOUT_EN
        cnt_d       = '0;
        err_d       = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (pick_any && !TX_BUSY) begin
                    state_d            = ST_LAUNCH;
                    gnt_d[pick_winner] = 1'b1;
                    tx_d_vld_d         = 1'b1;
                    tx_p_data_d        = REQ_DATA[int'(pick_winner)*DATA_WIDTH +: DATA_WIDTH];
                    active_id_d        = pick_winner;
                    last_d             = pick_winner;
                end
            end
            ST_LAUNCH: begin
                state_d = ST_WAIT_BUSY;
`ifdef UART_ARB_TIMEOUT_EN
                // The launch cycle counts toward the timeout so that ERR
                // lands TIMEOUT_CYC cycles after TX_D_VLD.
                cnt_d   = CNT_W'(1);
`endif
            end
            ST_WAIT_BUSY: begin
                if (TX_BUSY) begin
                    state_d = ST_WAIT_DONE;
                end
`ifdef UART_ARB_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                    // Drop the byte; last_q already points at this
                    // requester, so the next search moves past it.
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
`endif
            end
            ST_WAIT_DONE: begin
                if (!TX_BUSY) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q     <= ST_IDLE;
            gnt_q       <= '0;
            tx_d_vld_q  <= 1'b0;
            tx_p_data_q <= '0;
            active_id_q <= '0;
            last_q      <= ID_W'(NUM_REQ - 1);
`ifdef UART_ARB_TIMEOUT_EN
            cnt_q       <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            tx_d_vld_q  <= tx_d_vld_d;
            tx_p_data_q <= tx_p_data_d;
            active_id_q <= active_id_d;
            last_q      <= last_d;
`ifdef UART_ARB_TIMEOUT_EN
            cnt_q       <= cnt_d;
            err_q       <= err_d;
`endif
        end
    end

    assign GNT       = gnt_q;
    assign TX_D_VLD  = tx_d_vld_q;
    assign TX_P_DATA = tx_p_data_q;
    assign ACTIVE_ID = active_id_q;
`ifdef UART_ARB_TIMEOUT_EN
    assign ERR       = err_q;
`else
    assign ERR       = 1'b0;
`endif

endmodule
